// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit bundle: instruction/flags/memory handshake in, datapath enables and mux selects out.
// The controller takes the master modport; the datapath/memory side takes the slave modport.
interface mc_ctrl_fsm_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3
);
    logic [31:0]           instr;
    logic                  mem_ready;
    logic                  zero;
    logic                  carry;
    logic                  sign;
    logic                  overflow;
    logic                  mem_req;
    logic                  mem_write;
    logic                  adr_src;
    logic                  ir_write;
    logic                  pc_write;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [1:0]            alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [IMM_SRC_W-1:0]  imm_src;
    logic                  illegal;

    modport master (
        input  instr, mem_ready, zero, carry, sign, overflow,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal
    );

    modport slave (
        output instr, mem_ready, zero, carry, sign, overflow,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control unit: per-opcode state sequencing, memory handshake, ALU/imm decode.
// Optional perf counters (cycle_cnt, instret_cnt) are built only when MC_PERF_CNT_EN is defined.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC when memory completes
// DECODE   | branch/JAL target old_pc+imm -> ALUOut, dispatch on opcode
// MEMADR   | load/store address rs1+imm
// MEMRD    | load request, wait for mem_ready
// MEMWB    | write load data to rd
// MEMWR    | store request, wait for mem_ready
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// JAL      | PC <- target, old_pc+4 -> ALUOut
// JALR_A   | rs1+imm -> ALUOut
// JALR_B   | rd <- old_pc+4, PC <- ALUOut
// BRANCH   | compare rs1-rs2, conditional PC <- ALUOut
// LUI      | imm -> ALUOut
// AUIPC    | old_pc+imm -> ALUOut
// HALT     | illegal instruction, stuck until reset
module mc_ctrl_fsm #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_ctrl_fsm_if.master    bus,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R, S_EXEC_I,
        S_ALUWB, S_JAL, S_JALR_A, S_JALR_B, S_BRANCH, S_LUI, S_AUIPC, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    state_t     state, state_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] result_src, src_a, src_b;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[6:0];
    assign funct3            = bus.instr[14:12];
    assign funct7_5          = bus.instr[30];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // funct7[5] selects SUB only for register ops; it selects SRA/SRAI for both forms
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_sel = 3'd0;
            OP_STORE:                 imm_sel = 3'd1;
            OP_BRANCH:                imm_sel = 3'd2;
            OP_JAL:                   imm_sel = 3'd3;
            OP_LUI, OP_AUIPC:         imm_sel = 3'd4;
            default:                  imm_sel = 3'd0;
        endcase

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXEC_R;
                    OP_IMM:            state_n = S_EXEC_I;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR_A;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_LUI:            state_n = S_LUI;
                    OP_AUIPC:          state_n = S_AUIPC;
                    default:           state_n = S_HALT;
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_n = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) state_n = S_FETCH;
            end
            S_EXEC_R: begin
                src_a   = 2'b10;
                alu_op  = alu_decode(funct3, funct7_5, 1'b1);
                state_n = S_ALUWB;
            end
            S_EXEC_I: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = alu_decode(funct3, funct7_5, 1'b0);
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_JAL: begin
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                state_n  = S_ALUWB;
            end
            S_JALR_A: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_n = S_JALR_B;
            end
            // result_src=10 feeds rd with old_pc+4; the PC mux picks ALUOut independently
            S_JALR_B: begin
                src_a      = 2'b01;
                src_b      = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                state_n    = S_FETCH;
            end
            S_BRANCH: begin
                src_a   = 2'b10;
                alu_op  = ALU_SUB;
                state_n = S_FETCH;
                case (funct3)
                    3'b000:  pc_write = bus.zero;
                    3'b001:  pc_write = !bus.zero;
                    3'b100:  pc_write = bus.sign ^ bus.overflow;
                    3'b101:  pc_write = !(bus.sign ^ bus.overflow);
                    3'b110:  pc_write = bus.carry;
                    3'b111:  pc_write = !bus.carry;
                    default: state_n  = S_HALT;
                endcase
            end
            S_LUI: begin
                src_a   = 2'b11;
                src_b   = 2'b01;
                alu_op  = ALU_PASS;
                state_n = S_ALUWB;
            end
            S_AUIPC: begin
                src_a   = 2'b01;
                src_b   = 2'b01;
                state_n = S_ALUWB;
            end
            S_HALT: illegal = 1'b1;
            default: state_n = S_FETCH;
        endcase

        // reset abandons any pending memory request in the same cycle
        if (rst) begin
            state_n    = S_FETCH;
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
            result_src = 2'b00;
            src_a      = 2'b00;
            src_b      = 2'b00;
            alu_op     = ALU_ADD;
            imm_sel    = 3'd0;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_write   = mem_write;
    assign bus.adr_src     = adr_src;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.reg_write   = reg_write;
    assign bus.result_src  = result_src;
    assign bus.alu_src_a   = src_a;
    assign bus.alu_src_b   = src_b;
    assign bus.alu_control = ALU_CTRL_W'(alu_op);
    assign bus.imm_src     = IMM_SRC_W'(imm_sel);
    assign bus.illegal     = illegal;

`ifdef MC_PERF_CNT_EN
    logic retire;

    // FETCH is entered only from completing states, so any entry from elsewhere retires
    assign retire = !rst && (state_n == S_FETCH) && (state != S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected output timeline queued by the driver,
// checked every cycle by one compare process; retire/cycle counts modelled alongside.
module tb_mc_ctrl_fsm;
    localparam int AW = 4;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ALU_CTRL_W(AW), .IMM_SRC_W(IW)) ifc();

    mc_ctrl_fsm #(.ALU_CTRL_W(AW), .IMM_SRC_W(IW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       illegal;
        logic       retire;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc_no = 0;
    logic [CW-1:0] m_cyc = '0;
    logic [CW-1:0] m_ret = '0;

    function automatic logic [2:0] imm_of(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return 3'd0;
            7'b0100011:                         return 3'd1;
            7'b1100011:                         return 3'd2;
            7'b1101111:                         return 3'd3;
            7'b0110111, 7'b0010111:             return 3'd4;
            default:                            return 3'd0;
        endcase
    endfunction

    // ALU code from RISC-V semantics of the instruction
    function automatic logic [3:0] alu_of(input logic [31:0] ins, input logic is_r);
        case (ins[14:12])
            3'd0: return (is_r && ins[30]) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return ins[30] ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic exp_t blank(input logic [31:0] ins);
        exp_t e;
        e     = '0;
        e.imm = imm_of(ins);
        return e;
    endfunction

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b1;
        ifc.mem_ready = 1'b0;
        repeat (n) cyc('0);
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] ins, input int fw);
        exp_t e;
        ifc.instr = ins;
        e = blank(ins);
        e.mem_req = 1'b1; e.b = 2'd2; e.res = 2'd2;
        ifc.mem_ready = 1'b0;
        repeat (fw) cyc(e);
        ifc.mem_ready = 1'b1;
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc(e);
        e = blank(ins); e.a = 2'd1; e.b = 2'd1;
        cyc(e);
    endtask

    task automatic halt_cycles(input logic [31:0] ins);
        exp_t e;
        e = blank(ins); e.illegal = 1'b1;
        repeat (3) cyc(e);
        check_lit("halt_illegal_sticky", {31'd0, ifc.illegal}, 32'd1);
        do_reset(1);
    endtask

    // flg = {zero, carry, sign, overflow}
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic [3:0] flg);
        exp_t e, wb;
        logic lt_s, taken;
        {ifc.zero, ifc.carry, ifc.sign, ifc.overflow} = flg;
        fetch(ins, fw);
        wb = blank(ins); wb.reg_write = 1'b1; wb.retire = 1'b1;
        e  = blank(ins);
        case (ins[6:0])
            7'b0000011, 7'b0100011: begin
                e.a = 2'd2; e.b = 2'd1;
                cyc(e);
                e = blank(ins); e.mem_req = 1'b1; e.adr_src = 1'b1;
                e.mem_write = (ins[6:0] == 7'b0100011);
                ifc.mem_ready = 1'b0;
                repeat (mw) cyc(e);
                ifc.mem_ready = 1'b1;
                if (e.mem_write) begin
                    e.retire = 1'b1;
                    cyc(e);
                end else begin
                    cyc(e);
                    wb.res = 2'd1;
                    cyc(wb);
                end
            end
            7'b0110011, 7'b0010011: begin
                e.a = 2'd2; e.b = (ins[6:0] == 7'b0110011) ? 2'd0 : 2'd1;
                e.alu = alu_of(ins, ins[6:0] == 7'b0110011);
                cyc(e);
                cyc(wb);
            end
            7'b1101111: begin
                e.a = 2'd1; e.b = 2'd2; e.pc_write = 1'b1;
                cyc(e);
                cyc(wb);
            end
            7'b1100111: begin
                e.a = 2'd2; e.b = 2'd1;
                cyc(e);
                wb.a = 2'd1; wb.b = 2'd2; wb.res = 2'd2; wb.pc_write = 1'b1;
                cyc(wb);
            end
            7'b1100011: begin
                if (ins[14:13] == 2'b01) begin
                    e.a = 2'd2; e.alu = 4'd1;
                    cyc(e);
                    halt_cycles(ins);
                end else begin
                    lt_s = flg[1] ^ flg[0];
                    case (ins[14:12])
                        3'd0: taken = flg[3];
                        3'd1: taken = !flg[3];
                        3'd4: taken = lt_s;
                        3'd5: taken = !lt_s;
                        3'd6: taken = flg[2];
                        default: taken = !flg[2];
                    endcase
                    e.a = 2'd2; e.alu = 4'd1; e.pc_write = taken; e.retire = 1'b1;
                    cyc(e);
                end
            end
            7'b0110111: begin
                e.a = 2'd3; e.b = 2'd1; e.alu = 4'd10;
                cyc(e);
                cyc(wb);
            end
            7'b0010111: begin
                e.a = 2'd1; e.b = 2'd1;
                cyc(e);
                cyc(wb);
            end
            default: halt_cycles(ins);
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e, act;
        cyc_no++;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = '0;
            act.mem_req   = ifc.mem_req;
            act.mem_write = ifc.mem_write;
            act.adr_src   = ifc.adr_src;
            act.ir_write  = ifc.ir_write;
            act.pc_write  = ifc.pc_write;
            act.reg_write = ifc.reg_write;
            act.res       = ifc.result_src;
            act.a         = ifc.alu_src_a;
            act.b         = ifc.alu_src_b;
            act.alu       = ifc.alu_control;
            act.imm       = ifc.imm_src;
            act.illegal   = ifc.illegal;
            n_cmp++;
            if (act !== {e[$bits(exp_t)-1:1], 1'b0}) begin
                n_bad++;
                $display("FAIL outputs at cycle %0d instr %h: got %h want %h", cyc_no, ifc.instr, act, {e[$bits(exp_t)-1:1], 1'b0});
            end
            if (!rst) begin
                n_cmp++;
`ifdef MC_PERF_CNT_EN
                if (cycle_cnt !== m_cyc || instret_cnt !== m_ret) begin
`else
                if (cycle_cnt !== '0 || instret_cnt !== '0) begin
`endif
                    n_bad++;
                    $display("FAIL counters at cycle %0d: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                             cyc_no, cycle_cnt, instret_cnt, m_cyc, m_ret);
                end
            end
            if (rst) begin
                m_cyc = '0;
                m_ret = '0;
            end else begin
                m_cyc = m_cyc + 1'b1;
                if (e.retire) m_ret = m_ret + 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        ifc.instr = 32'h002081B3;
        ifc.mem_ready = 1'b0;
        {ifc.zero, ifc.carry, ifc.sign, ifc.overflow} = 4'b0000;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(32'h00500093, 1, 0, 4'b0000);   // ADDI, one fetch wait after reset
        run_instr(32'h002081B3, 0, 0, 4'b0000);   // ADD
        run_instr(32'h402081B3, 0, 0, 4'b0000);   // SUB
        run_instr(32'h4020D1B3, 0, 0, 4'b0000);   // SRA
        run_instr(32'h4030D193, 0, 0, 4'b0000);   // SRAI
        run_instr(32'h40008193, 0, 0, 4'b0000);   // ADDI imm bit30 set, still ADD
        run_instr(32'h0030B193, 0, 0, 4'b0000);   // SLTIU
        run_instr(32'h0FF0F193, 0, 0, 4'b0000);   // ANDI
        run_instr(32'h0020E1B3, 0, 0, 4'b0000);   // OR
        run_instr(32'h0020C1B3, 0, 0, 4'b0000);   // XOR
        run_instr(32'h0020A1B3, 0, 0, 4'b0000);   // SLT
        run_instr(32'h002091B3, 0, 0, 4'b0000);   // SLL
        run_instr(32'h0000A183, 3, 3, 4'b0000);   // LW, delayed fetch and read
        run_instr(32'h0030A023, 0, 2, 4'b0000);   // SW
        run_instr(32'h0020C063, 0, 0, 4'b0011);   // BLT sign=1 ovf=1: not taken
        run_instr(32'h0020D063, 0, 0, 4'b0010);   // BGE sign=1 ovf=0: not taken
        run_instr(32'h0020E063, 0, 0, 4'b0100);   // BLTU carry=1: taken
        run_instr(32'h0020F063, 0, 0, 4'b0100);   // BGEU carry=1: not taken
        run_instr(32'h00208063, 0, 0, 4'b0000);   // BEQ zero=0
        run_instr(32'h00208063, 0, 0, 4'b1000);   // BEQ zero=1
        run_instr(32'h00209063, 0, 0, 4'b0000);   // BNE zero=0
        run_instr(32'h008000EF, 0, 0, 4'b0000);   // JAL
        run_instr(32'h000080E7, 1, 0, 4'b0000);   // JALR
        run_instr(32'h123450B7, 0, 0, 4'b0000);   // LUI
        run_instr(32'h00001097, 0, 0, 4'b0000);   // AUIPC

        // reset during a pending load read
        fetch(32'h0000A183, 0);
        e = blank(32'h0000A183); e.a = 2'd2; e.b = 2'd1;
        cyc(e);
        e = blank(32'h0000A183); e.mem_req = 1'b1; e.adr_src = 1'b1;
        ifc.mem_ready = 1'b0;
        cyc(e);
        do_reset(1);
        run_instr(32'h002081B3, 2, 0, 4'b0000);

        run_instr(32'h0020A063, 0, 0, 4'b0000);   // branch funct3=010 halts
        run_instr(32'h0000007F, 0, 0, 4'b0000);   // unknown opcode halts
        check_lit("illegal_after_reset", {31'd0, ifc.illegal}, 32'd0);

        do_reset(1);
        repeat (20) run_instr(32'h00108093, 0, 0, 4'b0000);
`ifdef MC_PERF_CNT_EN
        check_lit("cycle_cnt_wrap", {28'd0, cycle_cnt}, 32'd0);
        check_lit("instret_cnt_wrap", {28'd0, instret_cnt}, 32'd4);
`else
        check_lit("cycle_cnt_tied", {28'd0, cycle_cnt}, 32'd0);
        check_lit("instret_cnt_tied", {28'd0, instret_cnt}, 32'd0);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
